// File: rtl/bit_rev_reorder_buf_if.sv
// Val/rdy stream bundle for the bit-reversal reorder buffer: natural-order words in, bit-reversed words out.
interface bit_rev_reorder_buf_if #(
  parameter int nbits    = 8,
  parameter int lg_depth = 3
);
  logic                in_val;
  logic                in_rdy;
  logic [nbits-1:0]    in_msg;
  logic                out_val;
  logic                out_rdy;
  logic [nbits-1:0]    out_msg;
  logic [lg_depth-1:0] out_idx;

  modport master (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg, out_idx
  );

  modport slave (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg, out_idx
  );
endinterface

// File: rtl/bit_rev_reorder_buf.sv
// Single-frame reorder buffer: fills 2^lg_depth words in order, then drains them in bit-reversed order.
// Output appears the cycle after the last write; out_rdy low holds the drain, and no input is taken while draining.
module bit_rev_reorder_buf #(
  parameter int nbits    = 8,
  parameter int lg_depth = 3
) (
  input logic                  clk,
  input logic                  reset,
  bit_rev_reorder_buf_if.slave io
);
  localparam int depth = 1 << lg_depth;
  localparam logic [lg_depth-1:0] last_idx = '1;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t              state;
  logic [lg_depth-1:0] wr_cnt;
  logic [lg_depth-1:0] rd_cnt;
  logic [lg_depth-1:0] rev_idx;
  logic                in_rdy_q;
  logic                out_val_q;
  logic                in_fire;
  logic                out_fire;
  logic [nbits-1:0]    mem [depth];

  assign in_fire  = io.in_val && in_rdy_q;
  assign out_fire = out_val_q && io.out_rdy;

  // Storage carries no reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_cnt] <= io.in_msg;
  end

  always_comb begin
    rev_idx = '0;
    for (int i = 0; i < lg_depth; i++) rev_idx[i] = rd_cnt[lg_depth-1-i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      in_rdy_q  <= 1'b0;
      out_val_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          in_rdy_q  <= 1'b1;
          out_val_q <= 1'b0;
          if (in_fire) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == last_idx) begin
              state     <= DRAIN;
              rd_cnt    <= '0;
              in_rdy_q  <= 1'b0;
              out_val_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == last_idx) begin
              state     <= FILL;
              in_rdy_q  <= 1'b1;
              out_val_q <= 1'b0;
            end
          end
        end
        default: begin
          state     <= FILL;
          in_rdy_q  <= 1'b0;
          out_val_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.in_rdy  = in_rdy_q;
  assign io.out_val = out_val_q;
  assign io.out_idx = out_val_q ? rev_idx : '0;
  assign io.out_msg = out_val_q ? mem[rev_idx] : '0;
endmodule

// File: tb/tb_bit_rev_reorder_buf.sv
// Scoreboard bench for bit_rev_reorder_buf over three parameter sets (8/3, 13/4, 8/1) sharing one clock and reset.
module tb_bit_rev_reorder_buf;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int sel = 0;
  int lgd = 3;

  logic        in_val_g  = 1'b0;
  logic        out_rdy_g = 1'b0;
  logic [15:0] in_msg_g  = 16'h0;
  logic        in_rdy_g;
  logic        out_val_g;
  logic [15:0] out_msg_g;
  logic [7:0]  out_idx_g;

  bit_rev_reorder_buf_if #(.nbits(8),  .lg_depth(3)) if0 ();
  bit_rev_reorder_buf_if #(.nbits(13), .lg_depth(4)) if1 ();
  bit_rev_reorder_buf_if #(.nbits(8),  .lg_depth(1)) if2 ();

  bit_rev_reorder_buf #(.nbits(8),  .lg_depth(3)) u0 (.clk(clk), .reset(reset), .io(if0.slave));
  bit_rev_reorder_buf #(.nbits(13), .lg_depth(4)) u1 (.clk(clk), .reset(reset), .io(if1.slave));
  bit_rev_reorder_buf #(.nbits(8),  .lg_depth(1)) u2 (.clk(clk), .reset(reset), .io(if2.slave));

  assign if0.in_val  = in_val_g && (sel == 0);
  assign if0.in_msg  = in_msg_g[7:0];
  assign if0.out_rdy = out_rdy_g && (sel == 0);
  assign if1.in_val  = in_val_g && (sel == 1);
  assign if1.in_msg  = in_msg_g[12:0];
  assign if1.out_rdy = out_rdy_g && (sel == 1);
  assign if2.in_val  = in_val_g && (sel == 2);
  assign if2.in_msg  = in_msg_g[7:0];
  assign if2.out_rdy = out_rdy_g && (sel == 2);

  always_comb begin
    in_rdy_g  = 1'b0;
    out_val_g = 1'b0;
    out_msg_g = 16'h0;
    out_idx_g = 8'h0;
    case (sel)
      0: begin
        in_rdy_g = if0.in_rdy; out_val_g = if0.out_val;
        out_msg_g = 16'(if0.out_msg); out_idx_g = 8'(if0.out_idx);
      end
      1: begin
        in_rdy_g = if1.in_rdy; out_val_g = if1.out_val;
        out_msg_g = 16'(if1.out_msg); out_idx_g = 8'(if1.out_idx);
      end
      default: begin
        in_rdy_g = if2.in_rdy; out_val_g = if2.out_val;
        out_msg_g = 16'(if2.out_msg); out_idx_g = 8'(if2.out_idx);
      end
    endcase
  end

  typedef struct {
    logic [7:0]  idx;
    logic [15:0] msg;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] stim_q[$];
  logic [15:0] frame[256];
  int          wr_m;
  int          checks = 0;
  int          failures = 0;
  int          outs_seen;
  int          low_cnt;
  bit          hold_prev;
  logic [15:0] prev_msg;
  logic [7:0]  prev_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic int bitrev(input int v, input int n);
    int r = 0;
    for (int i = 0; i < n; i++)
      if (((v >> i) & 1) != 0) r += 1 << (n - 1 - i);
    return r;
  endfunction

  // One clock of stimulus plus sampling; everything happens on the falling edge.
  task automatic step(input bit v, input bit r);
    exp_t e;
    int   ix;
    @(negedge clk);
    in_val_g  = v;
    in_msg_g  = v ? stim_q[0] : 16'hDEAD;
    out_rdy_g = r;
    #1;
    check("excl_rdy_val", 32'(in_rdy_g && out_val_g), 32'h0);
    if (!out_val_g) check("idle_out_zero", {out_msg_g, out_idx_g}, 32'h0);
    if (hold_prev) begin
      check("hold_val", 32'(out_val_g), 32'h1);
      check("hold_msg", 32'(out_msg_g), 32'(prev_msg));
      check("hold_idx", 32'(out_idx_g), 32'(prev_idx));
    end
    hold_prev = out_val_g && !r;
    prev_msg  = out_msg_g;
    prev_idx  = out_idx_g;
    if (!in_rdy_g) low_cnt++;
    if (v && in_rdy_g) begin
      frame[wr_m] = stim_q.pop_front();
      wr_m++;
      if (wr_m == (1 << lgd)) begin
        for (int k = 0; k < (1 << lgd); k++) begin
          ix    = bitrev(k, lgd);
          e.idx = 8'(ix);
          e.msg = frame[ix];
          sb.push_back(e);
        end
        wr_m = 0;
      end
    end
    if (out_val_g && r) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'h1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_idx", 32'(out_idx_g), 32'(e.idx));
        check("out_msg", 32'(out_msg_g), 32'(e.msg));
      end
      outs_seen++;
    end
  endtask

  // stop_outs < 0: run until all stimulus is taken and the scoreboard drains.
  task automatic run(input bit thr_in, input bit thr_out, input int stop_outs);
    bit done = 1'b0;
    outs_seen = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      step(stim_q.size() != 0 && !(thr_in && (c % 2 == 0)), !(thr_out && (c % 2 == 1)));
      done = (stim_q.size() == 0) && ((stop_outs < 0) ? (sb.size() == 0) : (outs_seen >= stop_outs));
    end
    check("run_done", 32'(done), 32'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_val_g  = 1'b0;
    out_rdy_g = 1'b0;
    reset     = 1'b1;
    #1;
    check("rst_in_rdy",  32'(in_rdy_g),  32'h0);
    check("rst_out_val", 32'(out_val_g), 32'h0);
    check("rst_out_msg", 32'(out_msg_g), 32'h0);
    check("rst_out_idx", 32'(out_idx_g), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    stim_q.delete();
    wr_m      = 0;
    hold_prev = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_rdy", 32'(in_rdy_g), 32'h1);
  endtask

  initial begin
    sel = 0; lgd = 3;
    do_reset();

    for (int i = 0; i < 8; i++) stim_q.push_back(16'h10 + 16'(i));
    low_cnt = 0;
    run(1'b0, 1'b0, -1);
    check("rdy_low_cycles", 32'(low_cnt), 32'd8);

    for (int i = 0; i < 8; i++) stim_q.push_back(16'h10 + 16'(i));
    run(1'b1, 1'b1, -1);

    for (int i = 0; i < 8; i++) stim_q.push_back(16'hA0 + 16'(i));
    for (int i = 0; i < 8; i++) stim_q.push_back(16'hB0 + 16'(i));
    run(1'b0, 1'b0, -1);

    for (int i = 0; i < 5; i++) stim_q.push_back(16'h30 + 16'(i));
    run(1'b0, 1'b0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) stim_q.push_back(16'(i));
    run(1'b0, 1'b0, -1);

    for (int i = 0; i < 8; i++) stim_q.push_back(16'h40 + 16'(i));
    run(1'b0, 1'b0, 3);
    do_reset();
    for (int i = 0; i < 8; i++) stim_q.push_back(16'(i));
    run(1'b0, 1'b0, -1);

    sel = 1; lgd = 4;
    do_reset();
    for (int i = 0; i < 16; i++) stim_q.push_back(16'h1000 + 16'(i));
    run(1'b0, 1'b0, -1);
    for (int i = 0; i < 48; i++) stim_q.push_back(16'($urandom_range(0, 8191)));
    run(1'b1, 1'b1, -1);

    sel = 2; lgd = 1;
    do_reset();
    stim_q.push_back(16'h55); stim_q.push_back(16'hAA);
    stim_q.push_back(16'h33); stim_q.push_back(16'hCC);
    run(1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bit_rev_reorder_buf.md
# bit_rev_reorder_buf

Single-frame reorder buffer that accepts a frame of 2^lg_depth words in natural order and emits them in bit-reversed index order. It is the standard input/output permutation stage for radix-2 FFT-style datapaths. The buffer sequences a parameterized bit-reversal of its read counter to form the read address. Both sides use latency-insensitive val/rdy handshakes.

## Interface
- nbits, default 8: data word width.
- lg_depth, default 3: log2 of frame length; depth = 2^lg_depth; legal range 1..8.

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all control state immediately.
- in_val  input  1  producer has a valid word on in_msg.
- in_rdy  output  1  buffer can accept a word this cycle.
- in_msg  input  nbits  input word.
- out_val  output  1  out_msg/out_idx are valid.
- out_rdy  input  1  consumer accepts the word this cycle.
- out_msg  output  nbits  output word.
- out_idx  output  lg_depth  natural-order index of the word on out_msg, i.e. bitrev(rd_cnt).

## Operation
- Storage is depth x nbits registers, written only in FILL. Storage is not reset.
- Control uses 2 states, FILL and DRAIN, plus wr_cnt and rd_cnt, each lg_depth bits wide.
- FILL:
  - in_rdy=1 and out_val=0.
  - When in_val && in_rdy: mem[wr_cnt] <= in_msg, and wr_cnt increments.
  - A write at wr_cnt == depth-1 wraps wr_cnt to 0 and moves to DRAIN next cycle, with rd_cnt=0.
- DRAIN:
  - in_rdy=0 and out_val=1.
  - out_idx = bitrev(rd_cnt): bit i of out_idx equals bit (lg_depth-1-i) of rd_cnt.
  - out_msg = mem[out_idx], a combinational read.
  - When out_val && out_rdy, rd_cnt increments.
  - A transfer at rd_cnt == depth-1 wraps rd_cnt to 0 and returns to FILL next cycle.
- When out_val=0, out_msg and out_idx are driven to 0.
- in_msg is ignored when in_val && in_rdy is false. out_rdy is ignored in FILL.
- No overlap: no input is accepted while draining, and no output is produced while filling.

## Timing
- Reset takes effect asynchronously while high and holds until the first rising edge after deassertion. During reset:
  - state = FILL, wr_cnt = 0, rd_cnt = 0.
  - in_rdy = 0, out_val = 0, out_msg = 0, out_idx = 0.
- In the first cycle after reset deasserts: in_rdy = 1.
- in_rdy and out_val depend only on registered state. There is no combinational path from in_val or out_rdy to any output.
- Minimum frame turnaround is 2·depth cycles:
  - the last input is accepted in cycle k;
  - out_val=1 from cycle k+1;
  - the last output is accepted in cycle k+depth, assuming out_rdy is held high;
  - in_rdy=1 again in cycle k+depth+1.
- Backpressure: while out_rdy=0, out_val, out_msg, out_idx and rd_cnt hold.
- Producer gaps: while in_val=0 in FILL, wr_cnt holds with no limit on gap length.
- Reset asserted mid-FILL or mid-DRAIN aborts the frame: partial data is discarded and the next frame starts at index 0.

## Test plan
- **Basic frame (nbits=8, lg_depth=3):** write 0x10..0x17 back-to-back with out_rdy=1.
  - Output sequence: 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17.
  - out_idx sequence: 0,4,2,6,1,5,3,7.
  - in_rdy low for exactly 8 cycles.
- **Throttled both sides:** same frame, with in_val low on alternate cycles and out_rdy low on alternate cycles.
  - Identical output order.
  - out_msg stable on every cycle where out_rdy=0.
  - No acceptance while in_rdy=0.
- **Back-to-back frames:** frame A = 0xA0..0xA7, then frame B = 0xB0..0xB7, with in_val held high throughout.
  - Frame B is accepted only after A drains.
  - B emits 0xB0,0xB4,0xB2,0xB6,0xB1,0xB5,0xB3,0xB7.
- **Reset mid-operation:**
  - Write 5 words, assert reset for 1 cycle, then write 0x00..0x07: output 0x00,0x04,0x02,0x06,0x01,0x05,0x03,0x07.
  - Repeat with reset asserted after 3 outputs of DRAIN: out_val drops immediately, and in_rdy=1 the cycle after deassertion.
- **Wide, odd parameters (nbits=13, lg_depth=4):** write 0x1000+i for i=0..15.
  - Output indices 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, each with matching data 0x1000+idx.
  - Also run 3 frames of random data against a software bit-reversal model.
- **Minimum size (lg_depth=1):** write 0x55, 0xAA.
  - Output 0x55 then 0xAA (bitrev is the identity).
  - State toggles correctly at wrap.
